// File: rtl/dll_code_ctrl_pkg.sv
// Shared definitions for the DLL delay-code controller: loop states and the
// default loop parameters.
package dll_code_ctrl_pkg;

    localparam int CODE_W_DEF    = 6;
    localparam int CODE_INIT_DEF = 0;
    localparam int VOTE_TH_DEF   = 4;
    localparam int LOCK_REV_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2,
        ST_HARM = 2'd3
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer whose flops come out of reset at 1, so an idle
// (high) input is what the downstream logic sees until real samples arrive.
module sync2 (
    input  logic clk_ext,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic sync_p0;

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            q       <= 1'b1;
        end else begin
            sync_p0 <= d;
            q       <= sync_p0;
        end
    end

endmodule

// File: rtl/dll_code_ctrl.sv
// Bang-bang DLL delay-code controller: integrates phase-detector votes, steps
// the delay select code, detects lock from direction reversals, and recovers
// from harmonic lock by restarting at the minimum delay.
module dll_code_ctrl
    import dll_code_ctrl_pkg::*;
#(
    parameter int CODE_W    = CODE_W_DEF,
    parameter int CODE_INIT = CODE_INIT_DEF,
    parameter int VOTE_TH   = VOTE_TH_DEF,
    parameter int LOCK_REV  = LOCK_REV_DEF
) (
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic              Reset_PD,
    input  logic              up,
    input  logic              dn,
    output logic [CODE_W-1:0] Sel,
    output logic              lock
);

    localparam int ACC_W = $clog2(VOTE_TH) + 2;
    localparam int REV_W = $clog2(LOCK_REV + 1);
    localparam logic signed [ACC_W-1:0] TH_POS = ACC_W'(VOTE_TH);
    localparam logic signed [ACC_W-1:0] TH_NEG = -TH_POS;
    localparam logic [CODE_W-1:0] SEL_INIT = CODE_W'(CODE_INIT);
    localparam logic [REV_W-1:0]  REV_MAX  = REV_W'(LOCK_REV);

    function automatic logic [CODE_W-1:0] sel_step(input logic [CODE_W-1:0] s,
                                                   input logic inc);
        if (inc)
            return (s == '1) ? s : s + 1'b1;
        else
            return (s == '0) ? s : s - 1'b1;
    endfunction

    function automatic logic [REV_W-1:0] rev_inc(input logic [REV_W-1:0] r);
        return (r == REV_MAX) ? r : r + 1'b1;
    endfunction

    logic                    pd_sync;
    logic                    harm;
    state_t                  state, state_nx;
    logic signed [ACC_W-1:0] acc, vote, acc_sum;
    logic [REV_W-1:0]        rev_cnt, rev_nx;
    logic                    dir_vld, dir_up;
    logic                    active, step_up, step_dn, step;
    logic                    reversal, same_dir;

    sync2 u_sync2 (
        .clk_ext (clk_ext),
        .rst_n   (rst_n),
        .d       (Reset_PD),
        .q       (pd_sync)
    );

    assign harm = ~pd_sync;

    always_comb begin
        case ({up, dn})
            2'b10:   vote = ACC_W'(1);
            2'b01:   vote = '1;
            default: vote = '0;
        endcase
    end

    assign acc_sum  = acc + vote;
    assign active   = (state == ST_ACQ) || (state == ST_LOCK);
    assign step_up  = active && !harm && (acc_sum == TH_POS);
    assign step_dn  = active && !harm && (acc_sum == TH_NEG);
    assign step     = step_up || step_dn;
    // Direction memory only qualifies a step once a prior step has set it.
    assign reversal = step && dir_vld && (dir_up != step_up);
    assign same_dir = step && dir_vld && (dir_up == step_up);

    always_comb begin
        rev_nx = rev_cnt;
        if (reversal)
            rev_nx = rev_inc(rev_cnt);
        else if (same_dir)
            rev_nx = '0;
    end

    always_comb begin
        state_nx = state;
        if (harm) begin
            state_nx = ST_HARM;
        end else begin
            case (state)
                ST_IDLE: state_nx = ST_ACQ;
                ST_ACQ:  if (reversal && (rev_nx == REV_MAX)) state_nx = ST_LOCK;
                ST_LOCK: if (same_dir) state_nx = ST_ACQ;
                ST_HARM: state_nx = ST_ACQ;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            Sel     <= SEL_INIT;
            acc     <= '0;
            rev_cnt <= '0;
            dir_vld <= 1'b0;
            dir_up  <= 1'b0;
            lock    <= 1'b0;
        end else begin
            state <= state_nx;
            lock  <= (state_nx == ST_LOCK);
            if (harm) begin
                Sel     <= SEL_INIT;
                acc     <= '0;
                rev_cnt <= '0;
                dir_vld <= 1'b0;
            end else if (active) begin
                rev_cnt <= rev_nx;
                if (step) begin
                    Sel     <= sel_step(Sel, step_up);
                    acc     <= '0;
                    dir_up  <= step_up;
                    dir_vld <= 1'b1;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_dll_code_ctrl.sv
// Testbench for dll_code_ctrl: vector tables of {up, dn, Reset_PD, cycles,
// expected Sel, expected lock} checked through a scoreboard queue.
module tb_dll_code_ctrl;

    logic       clk_ext = 1'b0;
    logic       rst_n;
    logic       Reset_PD;
    logic       up;
    logic       dn;
    logic [5:0] Sel;
    logic       lock;

    always #5 clk_ext = ~clk_ext;

    dll_code_ctrl dut (
        .clk_ext  (clk_ext),
        .rst_n    (rst_n),
        .Reset_PD (Reset_PD),
        .up       (up),
        .dn       (dn),
        .Sel      (Sel),
        .lock     (lock)
    );

    typedef struct {
        logic       up;
        logic       dn;
        logic       rpd;
        int         n;
        logic [5:0] sel;
        logic       lk;
    } vec_t;

    typedef struct {
        int         id;
        logic [5:0] sel;
        logic       lk;
    } exp_t;

    exp_t sb[$];
    vec_t va[10];
    vec_t vb[22];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic u, input logic d, input logic r,
                                input int n, input logic [5:0] s, input logic l);
        vec_t v;
        v.up = u; v.dn = d; v.rpd = r; v.n = n; v.sel = s; v.lk = l;
        return v;
    endfunction

    task automatic chk(input string nm, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, id, act, exp);
        end
    endtask

    // Drive one vector at a falling edge, hold it for v.n rising edges, then compare.
    task automatic run_vec(input vec_t v, input int id);
        exp_t e;
        up       = v.up;
        dn       = v.dn;
        Reset_PD = v.rpd;
        e.id  = id;
        e.sel = v.sel;
        e.lk  = v.lk;
        sb.push_back(e);
        repeat (v.n) @(negedge clk_ext);
        e = sb.pop_front();
        chk("sel", e.id, int'(Sel), int'(e.sel));
        chk("lock", e.id, int'(lock), int'(e.lk));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Ramp up to saturation, down to saturation, then stop mid-acquisition at 7.
        va[0] = mk(1, 0, 1,   4,  0, 0);
        va[1] = mk(1, 0, 1,   1,  1, 0);
        va[2] = mk(1, 0, 1,   4,  2, 0);
        va[3] = mk(1, 0, 1, 244, 63, 0);
        va[4] = mk(1, 0, 1,   8, 63, 0);
        va[5] = mk(0, 1, 1,   4, 62, 0);
        va[6] = mk(0, 1, 1, 248,  0, 0);
        va[7] = mk(0, 1, 1,   8,  0, 0);
        va[8] = mk(1, 0, 1,  28,  7, 0);
        va[9] = mk(1, 0, 1,   2,  7, 0);

        // Lock by reversals, lose lock, hold on conflicting votes, harmonic recovery.
        vb[0]  = mk(1, 0, 1, 41, 10, 0);
        vb[1]  = mk(1, 0, 1,  4, 11, 0);
        vb[2]  = mk(0, 1, 1,  4, 10, 0);
        vb[3]  = mk(1, 0, 1,  4, 11, 0);
        vb[4]  = mk(0, 1, 1,  4, 10, 0);
        vb[5]  = mk(1, 0, 1,  3, 10, 0);
        vb[6]  = mk(1, 0, 1,  1, 11, 1);
        vb[7]  = mk(0, 1, 1,  4, 10, 1);
        vb[8]  = mk(1, 0, 1,  4, 11, 1);
        vb[9]  = mk(1, 0, 1,  4, 12, 0);
        vb[10] = mk(1, 0, 1,  2, 12, 0);
        vb[11] = mk(1, 1, 1, 20, 12, 0);
        vb[12] = mk(1, 0, 1,  1, 12, 0);
        vb[13] = mk(1, 0, 1,  1, 13, 0);
        vb[14] = mk(0, 0, 1,  5, 13, 0);
        vb[15] = mk(1, 0, 1, 28, 20, 0);
        vb[16] = mk(1, 0, 1,  1, 20, 0);
        vb[17] = mk(1, 0, 0,  2, 20, 0);
        vb[18] = mk(1, 0, 0,  1,  0, 0);
        vb[19] = mk(1, 0, 1,  3,  0, 0);
        vb[20] = mk(1, 0, 1,  3,  0, 0);
        vb[21] = mk(1, 0, 1,  1,  1, 0);

        rst_n    = 1'b0;
        up       = 1'b0;
        dn       = 1'b0;
        Reset_PD = 1'b1;
        #1;
        chk("reset_sel", 0, int'(Sel), 0);
        chk("reset_lock", 0, int'(lock), 0);
        repeat (2) @(negedge clk_ext);
        chk("reset_hold_sel", 0, int'(Sel), 0);
        chk("reset_hold_lock", 0, int'(lock), 0);

        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) run_vec(va[i], i);

        // Reset asserted away from any clock edge must clear the code at once.
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 0, int'(Sel), 0);
        chk("async_rst_lock", 0, int'(lock), 0);
        @(negedge clk_ext);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) run_vec(vb[i], 100 + i);

        chk("sb_empty", 0, sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
